// File: rtl/booth_pp_accumulator_pkg.sv
// Shared constants, FSM encoding and slot helper for the Booth partial-product accumulator.
// Default slot geometry matches a 16x16 radix-4 Booth generator (8 slots of 32 bits).
package booth_pkg;

    localparam int NUM_PP = 8;
    localparam int PP_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Slot i of a default-geometry partial-product bus.
    function automatic logic [PP_W-1:0] pp_slot(input logic [NUM_PP*PP_W-1:0] bus,
                                                input int unsigned           i);
        return bus[i*PP_W +: PP_W];
    endfunction

endpackage

// File: rtl/booth_pp_accumulator_pp_slice_sum.sv
// Combinational sum of one group of PP_PER_CYCLE partial-product slots, modulo 2^PP_W.
// The loop unrolls into an adder chain that synthesis rebalances into a tree.
module pp_slice_sum #(
    parameter int PP_W         = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic [PP_PER_CYCLE*PP_W-1:0] slots,
    output logic [PP_W-1:0]              sum
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or loop, so no latch is inferred.
        sum = '0;
        for (int g = 0; g < PP_PER_CYCLE; g++) begin
            sum = sum + slots[g*PP_W +: PP_W];
        end
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential reduction of a radix-4 Booth partial-product bus into one signed product,
// PP_PER_CYCLE slots per cycle, with valid/ready handshakes on both sides.
module booth_pp_accumulator #(
    parameter int NUM_PP       = booth_pkg::NUM_PP,
    parameter int PP_W         = booth_pkg::PP_W,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PP*PP_W-1:0] in_pp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PP_W-1:0]        out_product,
    output logic                   busy
);

    import booth_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_PP) + 1;
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(PP_PER_CYCLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - PP_PER_CYCLE);

    state_t                   state;
    state_t                   next_state;
    logic [NUM_PP*PP_W-1:0]   pp_reg;
    logic [PP_W-1:0]          acc;
    logic [IDX_W-1:0]         idx;
    logic [PP_PER_CYCLE*PP_W-1:0] group;
    logic [PP_W-1:0]          group_sum;
    logic [PP_W-1:0]          acc_next;
    logic                     accept;
    logic                     last_group;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state == ACCUM);
    assign last_group = (idx == LAST_IDX);
    assign acc_next   = acc + group_sum;

    // Pick the PP_PER_CYCLE slots starting at idx out of the latched bus.
    always_comb begin
        group = '0;
        for (int g = 0; g < PP_PER_CYCLE; g++) begin
            group[g*PP_W +: PP_W] = pp_reg[(int'(idx) + g)*PP_W +: PP_W];
        end
    end

    pp_slice_sum #(
        .PP_W         (PP_W),
        .PP_PER_CYCLE (PP_PER_CYCLE)
    ) u_slice_sum (
        .slots (group),
        .sum   (group_sum)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = ACCUM;
            ACCUM:   if (last_group) next_state = DONE;
            DONE:    if (out_ready) next_state = in_valid ? ACCUM : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            idx         <= '0;
            out_product <= '0;
            out_valid   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                acc <= '0;
                idx <= '0;
            end else if (state == ACCUM) begin
                acc <= acc_next;
                idx <= idx + STEP;
                if (last_group) begin
                    out_product <= acc_next;
                    out_valid   <= 1'b1;
                end
            end
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: pp_reg is pure datapath, always reloaded on accept before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pp_reg <= in_pp;
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: latency, holds, back-to-back, reset abort, wider groups.
// A small radix-4 Booth generator builds the input bus; expected products are hand-computed.
module tb_booth_pp_accumulator;

    localparam int NUM_PP = 8;
    localparam int PP_W   = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_PP*PP_W-1:0] in_pp;
    logic                   out_valid;
    logic                   out_ready;
    logic [PP_W-1:0]        out_product;
    logic                   busy;

    logic                   in_valid4, in_ready4, out_valid4, busy4;
    logic [PP_W-1:0]        out_product4;
    logic                   in_valid8, in_ready8, out_valid8, busy8;
    logic [PP_W-1:0]        out_product8;

    int checks   = 0;
    int failures = 0;

    booth_pp_accumulator #(.NUM_PP(NUM_PP), .PP_W(PP_W), .PP_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .busy(busy)
    );

    booth_pp_accumulator #(.NUM_PP(NUM_PP), .PP_W(PP_W), .PP_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_pp(in_pp),
        .out_valid(out_valid4), .out_ready(1'b1), .out_product(out_product4), .busy(busy4)
    );

    booth_pp_accumulator #(.NUM_PP(NUM_PP), .PP_W(PP_W), .PP_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_pp(in_pp),
        .out_valid(out_valid8), .out_ready(1'b1), .out_product(out_product8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Radix-4 Booth recoding of b, each slot digit*a shifted by 2i and sign-extended.
    function automatic logic [NUM_PP*PP_W-1:0] booth_bus(input logic signed [15:0] a,
                                                         input logic signed [15:0] b);
        logic [NUM_PP*PP_W-1:0] bus;
        logic [16:0]            bx;
        logic [2:0]             trip;
        int                     digit;
        int                     p;
        bus = '0;
        bx  = {b, 1'b0};
        for (int i = 0; i < NUM_PP; i++) begin
            trip = bx[2*i +: 3];
            case (trip)
                3'b001, 3'b010: digit = 1;
                3'b011:         digit = 2;
                3'b100:         digit = -2;
                3'b101, 3'b110: digit = -1;
                default:        digit = 0;
            endcase
            p = (digit * int'(a)) <<< (2*i);
            bus[i*PP_W +: PP_W] = p;
        end
        return bus;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_out(input int budget, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // Present operands while idle, accept on the next edge, return #1 after that edge.
    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
        in_pp    = booth_bus(a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic mult(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic [31:0] expected);
        int cyc;
        send(a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_out(40, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_product"}, out_product, expected);
        @(posedge clk); #1;
        check({tag, "_release"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        in_pp     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", out_product, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Basic products, 8-cycle latency.
        mult("m3x5", 16'sd3, 16'sd5, 32'h0000000F);
        mult("mmin", -16'sd32768, -16'sd32768, 32'h40000000);
        mult("mneg1", -16'sd1, 16'sd1, 32'hFFFFFFFF);

        // Downstream stall: result held, no new input accepted.
        out_ready = 1'b0;
        send(16'sd1234, -16'sd567);
        check("stall_in_ready_accum", 32'(in_ready), 32'd0);
        wait_out(40, cyc);
        check("stall_latency", 32'(cyc), 32'd8);
        check("stall_product", out_product, 32'hFFF552E2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_product", out_product, 32'hFFF552E2);
            check("stall_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("stall_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall_released", 32'(out_valid), 32'd0);
        check("stall_idle", 32'(busy), 32'd0);

        // Back-to-back; the bus switches right after accept and must not disturb the first result.
        in_pp    = booth_bus(16'sd7, 16'sd9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_pp = booth_bus(-16'sd2, 16'sd100);
        wait_out(40, cyc);
        check("b2b_first_latency", 32'(cyc), 32'd8);
        check("b2b_first_product", out_product, 32'd63);
        check("b2b_in_ready_done", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_reaccept_valid", 32'(out_valid), 32'd0);
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_spacing", 32'(cyc), 32'd9);
        check("b2b_second_product", out_product, 32'hFFFFFF38);
        @(posedge clk); #1;
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Reset while accumulating at idx=4 aborts the multiply.
        send(16'sd1234, 16'sd100);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_product", out_product, 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        mult("after_abort", -16'sd123, 16'sd45, 32'hFFFFEA61);

        // Four slots per cycle: latency 2.
        in_pp     = booth_bus(16'sd100, 16'sd100);
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check("g4_busy", 32'(busy4), 32'd1);
        cyc = 0;
        while (!out_valid4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("g4_latency", 32'(cyc), 32'd2);
        check("g4_product", out_product4, 32'd10000);

        // Eight slots per cycle: latency 1.
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("g8_busy", 32'(busy8), 32'd1);
        cyc = 0;
        while (!out_valid8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("g8_latency", 32'(cyc), 32'd1);
        check("g8_product", out_product8, 32'd10000);
        check("g8_in_ready", 32'(in_ready8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
